// File: rtl/r5p_tcm_pkg.sv
// r5p_tcm_pkg: shared types for the r5p tightly coupled memory responder
package r5p_tcm_pkg;
  typedef enum logic {IDLE, WAIT} ws_state_t;
  typedef logic [3:0] ws_cnt_t;
endpackage

// File: rtl/r5p_tcm_ws.sv
// r5p_tcm_ws: per-port wait-state generator; ack after WS stalled request cycles
module r5p_tcm_ws
  import r5p_tcm_pkg::*;
#(
  parameter int WS = 0
)(
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic ack
);
  ws_state_t r_state, w_state;
  ws_cnt_t   r_cnt, w_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
    end
  // the counter holds the stall cycles still owed after the current one
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    if (WS == 0 || !req) begin
      w_state = IDLE;
      w_cnt   = '0;
    end else if (r_state == IDLE) begin
      w_state = WAIT;
      w_cnt   = ws_cnt_t'(WS - 1);
    end else if (r_cnt == '0)
      w_state = IDLE;
    else
      w_cnt = r_cnt - 1'b1;
  end
  always_comb ack = (WS == 0) ? req : (req && r_state == WAIT && r_cnt == '0);
endmodule

// File: rtl/r5p_tcm.sv
// r5p_tcm: dual-port (fetch + load/store) byte-addressed TCM for the r5p core
module r5p_tcm
  import r5p_tcm_pkg::*;
#(
  parameter int    IAW  = 32,
  parameter int    IDW  = 32,
  parameter int    ISW  = IDW/8,
  parameter int    DAW  = 32,
  parameter int    DDW  = 32,
  parameter int    DSW  = DDW/8,
  parameter int    SIZE = 4096,
  parameter int    IWS  = 0,
  parameter int    LWS  = 0,
  parameter string FN   = ""
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [IAW-1:0]   if_adr,
  output logic [ISW*8-1:0] if_rdt,
  output logic             if_ack,
  input  logic             ls_req,
  input  logic             ls_wen,
  input  logic [DAW-1:0]   ls_adr,
  input  logic [DSW-1:0]   ls_sel,
  input  logic [DSW*8-1:0] ls_wdt,
  output logic [DSW*8-1:0] ls_rdt,
  output logic             ls_ack
`ifdef R5P_TCM_BOUNDS_EN
  ,
  output logic             ls_err
`endif
);
  localparam int AW = $clog2(SIZE);
  localparam int IL = $clog2(ISW);
  localparam int DL = $clog2(DSW);
  logic [7:0]       r_mem [SIZE];
  logic [ISW*8-1:0] r_if_rdt, w_if_dat;
  logic [DSW*8-1:0] r_ls_rdt, w_ls_dat;
  logic [AW-IL-1:0] w_if_idx;
  logic [AW-DL-1:0] w_ls_idx;
  logic             w_if_oor, w_ls_oor, w_if_xfr, w_ls_xfr, w_unused;
  r5p_tcm_ws #(.WS(IWS)) u_if_ws (.clk(clk), .rst(rst), .req(if_req), .ack(if_ack));
  r5p_tcm_ws #(.WS(LWS)) u_ls_ws (.clk(clk), .rst(rst), .req(ls_req), .ack(ls_ack));
  assign w_if_idx = if_adr[AW-1:IL];
  assign w_ls_idx = ls_adr[AW-1:DL];
  assign w_if_xfr = if_req && if_ack && !rst;
  assign w_ls_xfr = ls_req && ls_ack && !rst;
`ifdef R5P_TCM_BOUNDS_EN
  logic r_err;
  assign w_if_oor = |if_adr[IAW-1:AW];
  assign w_ls_oor = |ls_adr[DAW-1:AW];
  assign w_unused = ^{if_adr[IL-1:0], ls_adr[DL-1:0]};
  always_ff @(posedge clk or posedge rst)
    if (rst)
      r_err <= 1'b0;
    else if ((w_if_xfr && w_if_oor) || (w_ls_xfr && w_ls_oor))
      r_err <= 1'b1;
  assign ls_err = r_err;
`else
  assign w_if_oor = 1'b0;
  assign w_ls_oor = 1'b0;
  assign w_unused = ^{if_adr[IL-1:0], if_adr[IAW-1:AW], ls_adr[DL-1:0], ls_adr[DAW-1:AW]};
`endif
  for (genvar g = 0; g < ISW; g++) begin : g_if
    assign w_if_dat[g*8+:8] = w_if_oor ? 8'h00 : r_mem[{w_if_idx, IL'(g)}];
  end
  for (genvar g = 0; g < DSW; g++) begin : g_ls
    assign w_ls_dat[g*8+:8] = w_ls_oor ? 8'h00 : r_mem[{w_ls_idx, DL'(g)}];
  end
  always_ff @(posedge clk)
    if (w_ls_xfr && ls_wen && !w_ls_oor)
      for (int i = 0; i < DSW; i++)
        if (ls_sel[i]) r_mem[{w_ls_idx, DL'(i)}] <= ls_wdt[i*8+:8];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_if_rdt <= '0;
      r_ls_rdt <= '0;
    end else begin
      if (w_if_xfr) r_if_rdt <= w_if_dat;
      if (w_ls_xfr && !ls_wen) r_ls_rdt <= w_ls_dat;
    end
  assign if_rdt = r_if_rdt;
  assign ls_rdt = r_ls_rdt;
endmodule

// File: tb/tb_r5p_tcm.sv
// tb_r5p_tcm: directed stimulus for r5p_tcm (IWS=0, LWS=3) checked each cycle against a behavioural model.
module tb_r5p_tcm;
  localparam int SIZE = 4096;
  localparam int IWS = 0;
  localparam int LWS = 3;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, ls_req = 1'b0, ls_wen = 1'b0, if_ack, ls_ack;
  logic [31:0] if_adr = '0, ls_adr = '0, ls_wdt = '0, if_rdt, ls_rdt;
  logic [3:0]  ls_sel = '0;
  logic        ls_err;
  int          checks = 0, errors = 0;
  int          n;
  logic [7:0]  mask;

  r5p_tcm #(.SIZE(SIZE), .IWS(IWS), .LWS(LWS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_adr(if_adr), .if_rdt(if_rdt), .if_ack(if_ack),
    .ls_req(ls_req), .ls_wen(ls_wen), .ls_adr(ls_adr), .ls_sel(ls_sel),
    .ls_wdt(ls_wdt), .ls_rdt(ls_rdt), .ls_ack(ls_ack)
`ifdef R5P_TCM_BOUNDS_EN
    , .ls_err(ls_err)
`endif
  );
`ifndef R5P_TCM_BOUNDS_EN
  assign ls_err = 1'b0;
`endif

  always #5 clk = ~clk;

  // model: byte memory, per-port count of consecutive stalled request cycles
  logic [7:0]  m_mem [SIZE];
  int          k_if = 0, k_ls = 0;
  logic [31:0] e_if_rdt = '0, e_ls_rdt = '0;
  logic        e_err = 1'b0;

  function automatic bit oor(input logic [31:0] a);
`ifdef R5P_TCM_BOUNDS_EN
    return a >= SIZE;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int base(input logic [31:0] a);
    return (int'(a % SIZE) / 4) * 4;
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i+:8] = m_mem[base(a) + i];
    return oor(a) ? 32'h0 : w;
  endfunction

  function automatic bit e_ack(input bit req, input int k, input int ws);
    return req && (rst ? (ws == 0) : (k >= ws));
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) begin
      k_if     <= 0;
      k_ls     <= 0;
      e_if_rdt <= '0;
      e_ls_rdt <= '0;
      e_err    <= 1'b0;
    end else begin
      if (if_req && k_if >= IWS) e_if_rdt <= rd(if_adr);
      if (ls_req && k_ls >= LWS && !ls_wen) e_ls_rdt <= rd(ls_adr);
      if (ls_req && k_ls >= LWS && ls_wen && !oor(ls_adr))
        for (int i = 0; i < 4; i++)
          if (ls_sel[i]) m_mem[base(ls_adr) + i] <= ls_wdt[8*i+:8];
      if ((if_req && k_if >= IWS && oor(if_adr)) || (ls_req && k_ls >= LWS && oor(ls_adr)))
        e_err <= 1'b1;
      k_if <= (if_req && k_if < IWS) ? k_if + 1 : 0;
      k_ls <= (ls_req && k_ls < LWS) ? k_ls + 1 : 0;
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("if_ack", {31'b0, if_ack}, {31'b0, e_ack(if_req, k_if, IWS)});
    chk("ls_ack", {31'b0, ls_ack}, {31'b0, e_ack(ls_req, k_ls, LWS)});
    chk("if_rdt", if_rdt, e_if_rdt);
    chk("ls_rdt", ls_rdt, e_ls_rdt);
    chk("ls_err", {31'b0, ls_err}, {31'b0, e_err});
  end

  task automatic cyc(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  // hold a load/store request until ack; optionally fetch fa on the ack cycle
  task automatic ls_xfer(input bit w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input bit f, input logic [31:0] fa, output int c);
    bit done;
    ls_req = 1'b1; ls_wen = w; ls_adr = a; ls_sel = s; ls_wdt = d;
    c = 0;
    done = 1'b0;
    while (!done && c < 20) begin
      c++;
      #1;
      done = ls_ack;
      if (done && f) begin
        if_req = 1'b1;
        if_adr = fa;
      end
      cyc(1);
    end
    ls_req = 1'b0; if_req = 1'b0;
    chk("ls_timeout", {31'b0, done}, 32'd1);
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] exp);
    if_req = 1'b1; if_adr = a;
    #1;
    chk("fetch_same_cycle_ack", {31'b0, if_ack}, 32'd1);
    cyc(1);
    if_req = 1'b0;
    chk("fetch_data", if_rdt, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(2);
    chk("rst_if_rdt", if_rdt, 32'h0);
    chk("rst_ls_rdt", ls_rdt, 32'h0);
    if_req = 1'b1; ls_req = 1'b1;
    #1;
    chk("rst_if_ack_follows_req", {31'b0, if_ack}, 32'd1);
    chk("rst_ls_ack_low", {31'b0, ls_ack}, 32'd0);
    cyc(1);
    if_req = 1'b0; ls_req = 1'b0;
    rst = 1'b0;
    cyc(1);
    ls_xfer(1, 32'h0, 4'hF, 32'h00000013, 0, 0, n);
    chk("ws3_write_ack_cycle", n, 4);
    fetch(32'h0, 32'h00000013);
    ls_xfer(1, 32'h104, 4'hF, 32'h11223344, 0, 0, n);
    ls_xfer(1, 32'h104, 4'b0100, 32'h00AB0000, 0, 0, n);
    ls_xfer(0, 32'h104, 4'hF, 32'h0, 0, 0, n);
    chk("byte_write_merge", ls_rdt, 32'h11AB3344);
    ls_req = 1'b1; ls_wen = 1'b0; ls_adr = 32'h104; mask = '0;
    for (int c = 0; c < 8; c++) begin
      #1;
      mask[c] = ls_ack;
      cyc(1);
    end
    ls_req = 1'b0;
    chk("b2b_ack_cycles_4_8", {24'b0, mask}, 32'h88);
    ls_xfer(1, 32'h200, 4'hF, 32'hCAFEF00D, 0, 0, n);
    ls_req = 1'b1; ls_wen = 1'b1; ls_adr = 32'h200; ls_wdt = 32'h0;
    cyc(1);
    ls_req = 1'b0;
    cyc(1);
    ls_xfer(0, 32'h200, 4'hF, 32'h0, 0, 0, n);
    chk("drop_recount_cycles", n, 4);
    chk("drop_no_write", ls_rdt, 32'hCAFEF00D);
    ls_req = 1'b1; ls_wen = 1'b1; ls_adr = 32'h200; ls_wdt = 32'h0;
    cyc(2);
    rst = 1'b1;
    #1;
    chk("rst_mid_wait_ack", {31'b0, ls_ack}, 32'd0);
    ls_req = 1'b0;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    chk("rst_mid_wait_rdt", ls_rdt, 32'h0);
    ls_xfer(0, 32'h200, 4'hF, 32'h0, 0, 0, n);
    chk("rst_mid_wait_no_write", ls_rdt, 32'hCAFEF00D);
    ls_xfer(1, 32'h20, 4'hF, 32'h01234567, 0, 0, n);
    ls_xfer(1, 32'h20, 4'hF, 32'hDEADBEEF, 1, 32'h20, n);
    chk("read_before_write", if_rdt, 32'h01234567);
    fetch(32'h20, 32'hDEADBEEF);
`ifdef R5P_TCM_BOUNDS_EN
    ls_xfer(1, 32'h1000, 4'hF, 32'h55555555, 0, 0, n);
    chk("oor_write_acked", n, 4);
    chk("oor_err_set", {31'b0, ls_err}, 32'd1);
    ls_xfer(0, 32'h0, 4'hF, 32'h0, 0, 0, n);
    chk("oor_word0_kept", ls_rdt, 32'h00000013);
    fetch(32'h1000, 32'h0);
    cyc(3);
    chk("oor_err_sticky", {31'b0, ls_err}, 32'd1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    chk("oor_err_cleared", {31'b0, ls_err}, 32'd0);
`else
    ls_xfer(1, 32'h1000, 4'hF, 32'h55555555, 0, 0, n);
    fetch(32'h0, 32'h55555555);
`endif
    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
